// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline stage:
//   - pipe_state_t : stage fill state (EMPTY / BUSY / FULL)
//   - OCC_W        : width of the occupancy count
//   - STALL_CNT_W  : width of the downstream-stall counter
//   - STALL_CNT_MAX: saturation value of the downstream-stall counter
//   - occ_of_state : maps a fill state to the number of words held
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int OCC_W       = 2;
  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

  // Number of words held in a given fill state.
  function automatic logic [OCC_W-1:0] occ_of_state(input pipe_state_t st);
    logic [OCC_W-1:0] occ;
    case (st)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
// Elastic valid/ready pipeline stage with a main and a skid register. Every
// output, including in_ready, comes straight from a flop, so downstream
// backpressure never forms a combinational path back to the upstream side.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   clear      synchronous flush; drops all held words (beats any transfer)
//   in_valid   upstream word present
//   in_ready   stage can accept a word this cycle (registered)
//   in_data    upstream word [WIDTH]
//   out_valid  out_data holds a valid word (registered)
//   out_ready  downstream accepts the word this cycle
//   out_data   head word, i.e. the main register [WIDTH]
//   occupancy  words held: 0, 1 or 2
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
//
// Build option:
//   PIPE_SKID_STALL_STATS_EN - when defined, stall_cnt is a live saturating
//   counter; otherwise it is tied to zero and no counter logic exists.
// ---------------------------------------------------------------------------
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [OCC_W-1:0]       occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_t      state_r;
  pipe_state_t      state_nxt_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_nxt_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [OCC_W-1:0] occupancy_r;
  logic             in_xfer_s;
  logic             out_xfer_s;

  assign in_xfer_s  = in_valid  & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  // Next-state and data-register update rules; clear overrides every transfer.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (clear) begin
      state_nxt_s = EMPTY;
      main_nxt_s  = '0;
      skid_nxt_s  = '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_xfer_s) begin
            state_nxt_s = BUSY;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        BUSY: begin
          if (in_xfer_s && out_xfer_s) begin
            state_nxt_s = BUSY;
            main_nxt_s  = in_data;
          end else if (in_xfer_s) begin
            // Downstream stalled: the new word parks behind the head.
            state_nxt_s = FULL;
            skid_nxt_s  = in_data;
          end else if (out_xfer_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = BUSY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer_s) begin
            state_nxt_s = BUSY;
            main_nxt_s  = skid_r;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
          main_nxt_s  = '0;
          skid_nxt_s  = '0;
        end
      endcase
    end
  end

  // State, data registers and the flags derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      in_ready_r  <= (state_nxt_s != FULL);
      out_valid_r <= (state_nxt_s != EMPTY);
      occupancy_r <= occ_of_state(state_nxt_s);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occupancy_r;

`ifdef PIPE_SKID_STALL_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  // Saturating count of cycles where a held word is refused downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if (clear) begin
      stall_cnt_r <= 16'h0000;
    end else if (out_valid_r && !out_ready && (stall_cnt_r != STALL_CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
// Directed bench for pipe_skid_stage. Inputs change and outputs are sampled
// 1 time unit after each rising clock edge. Stall-counter expectations follow
// the PIPE_SKID_STALL_STATS_EN build option.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  int vectors;
  int miscompares;

  pipe_skid_stage #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stall(input string tag, input logic [15:0] exp_en);
`ifdef PIPE_SKID_STALL_STATS_EN
    check(tag, stall_cnt, exp_en);
`else
    check(tag, stall_cnt, 16'h0000);
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_in_ready",  {15'd0, in_ready},  16'h0000);
    check("rst_occ",       {14'd0, occupancy}, 16'h0000);
    check("rst_out_data",  {8'd0, out_data},   16'h0000);
    check_stall("rst_stall", 16'h0000);
    reset = 1'b0;
    #2;
    check("in_ready_low_before_edge", {15'd0, in_ready}, 16'h0000);
    step();
    check("in_ready_after_reset", {15'd0, in_ready}, 16'h0001);

    // Single word, 1-cycle latency
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_valid", {15'd0, out_valid}, 16'h0001);
    check("single_data",  {8'd0, out_data},   16'h00A5);
    check("single_occ",   {14'd0, occupancy}, 16'h0001);
    step();
    check("single_drained", {15'd0, out_valid}, 16'h0000);
    check("single_occ0",    {14'd0, occupancy}, 16'h0000);

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      check("stream_data",     {8'd0, out_data},   16'(i));
      check("stream_valid",    {15'd0, out_valid}, 16'h0001);
      check("stream_in_ready", {15'd0, in_ready},  16'h0001);
      check("stream_occ",      {14'd0, occupancy}, 16'h0001);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", {15'd0, out_valid}, 16'h0000);

    // Backpressure fills the skid register, then drains in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h10;
    step();
    in_data = 8'h11;
    step();
    in_valid = 1'b0;
    check("full_occ",      {14'd0, occupancy}, 16'h0002);
    check("full_in_ready", {15'd0, in_ready},  16'h0000);
    check("full_data",     {8'd0, out_data},   16'h0010);
    step();
    check("full_hold_data", {8'd0, out_data},   16'h0010);
    check("full_hold_occ",  {14'd0, occupancy}, 16'h0002);
    // FULL with out_ready and in_valid: only the output moves, 0x12 ignored
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h12;
    step();
    in_valid = 1'b0;
    check("drain1_data",     {8'd0, out_data},   16'h0011);
    check("drain1_occ",      {14'd0, occupancy}, 16'h0001);
    check("drain1_in_ready", {15'd0, in_ready},  16'h0001);
    step();
    check("drain2_valid",    {15'd0, out_valid}, 16'h0000);
    check("drain2_in_ready", {15'd0, in_ready},  16'h0001);

    // Clear while FULL drops held words and the word offered that cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h20;
    step();
    in_data = 8'h21;
    step();
    check("pre_clear_occ", {14'd0, occupancy}, 16'h0002);
    in_data = 8'h22; clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    check("clear_valid",    {15'd0, out_valid}, 16'h0000);
    check("clear_occ",      {14'd0, occupancy}, 16'h0000);
    check("clear_data",     {8'd0, out_data},   16'h0000);
    check("clear_in_ready", {15'd0, in_ready},  16'h0001);
    check_stall("clear_stall", 16'h0000);
    out_ready = 1'b1;
    step();
    check("clear_no_22", {15'd0, out_valid}, 16'h0000);

    // Stall counter: 5 stalled cycles with one word held
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h30;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check("stall_hold_data", {8'd0, out_data}, 16'h0030);
    check_stall("stall_5", 16'h0005);
`ifdef PIPE_SKID_STALL_STATS_EN
    repeat (65530) step();
    check("stall_max", stall_cnt, 16'hFFFF);
    repeat (3) step();
    check("stall_sat", stall_cnt, 16'hFFFF);
`endif
    out_ready = 1'b1;
    step();
    check("stall_drained", {15'd0, out_valid}, 16'h0000);
    check_stall("stall_after_drain", 16'hFFFF);

    // Asynchronous reset while FULL takes effect before the next edge
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h40;
    step();
    in_data = 8'h41;
    step();
    in_valid = 1'b0;
    check("pre_reset_occ", {14'd0, occupancy}, 16'h0002);
    #2;
    reset = 1'b1;
    #1;
    check("async_out_valid", {15'd0, out_valid}, 16'h0000);
    check("async_in_ready",  {15'd0, in_ready},  16'h0000);
    check("async_occ",       {14'd0, occupancy}, 16'h0000);
    check("async_data",      {8'd0, out_data},   16'h0000);
    check_stall("async_stall", 16'h0000);
    step();
    reset = 1'b0;
    step();
    check("post_reset_in_ready", {15'd0, in_ready}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
